// File: rtl/systolic_drain_if.sv
// Output stream of the systolic column drain controller.
//   outData  : element data, bit-exact accumulator value
//   outValid : element present on outData
//   outReady : consumer accepts the element this cycle
//   outLast  : marks the final element of one drain
// master drives data/valid/last and samples ready; slave is the consumer.
interface systolic_drain_if #(
   parameter int unsigned W = 14
) ();
   logic [W-1:0] outData;
   logic         outValid;
   logic         outReady;
   logic         outLast;

   modport master (
      output outData,
      output outValid,
      output outLast,
      input  outReady
   );

   modport slave (
      input  outData,
      input  outValid,
      input  outLast,
      output outReady
   );
endinterface

// File: rtl/systolic_drain.sv
// Readout controller at the tail of a systolic PE column. On start it shifts the column out one
// PE per cycle, buffers each accumulator in a small FIFO and presents them bottom PE first as a
// valid/ready stream. The chain head is driven with zero so the column ends up cleared.
// Ports:
//   clock, reset   : sole clock, synchronous active-high reset
//   start          : drain request, honoured only when idle
//   mulBusy        : multiply phase in progress, holds off shifting
//   chainTail      : cOut of the last PE
//   chainHead      : cIn of the first PE, constant zero
//   enableShiftOut : registered shift enable to every PE
//   stream         : output stream (data/valid/last/ready)
//   busy           : drain or flush in progress
//   done           : one-cycle pulse when the drain has fully left the FIFO
module systolic_drain #(
   parameter int unsigned ROWS     = 8,
   parameter int unsigned EXP_OUT  = 5,
   parameter int unsigned FRAC_OUT = 8,
   parameter int unsigned DEPTH    = 4,
   localparam int unsigned W       = EXP_OUT + FRAC_OUT + 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 mulBusy,
   input  logic [W-1:0]         chainTail,
   output logic [W-1:0]         chainHead,
   output logic                 enableShiftOut,
   systolic_drain_if.master     stream,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned ShW  = $clog2(ROWS + 1);

   typedef enum logic [1:0] {StIdle, StDrain, StFlush} state_e;

   state_e            state_q, state_d;
   logic [ShW-1:0]    shifts_q, shifts_d;
   logic              en_q, en_d;
   logic              done_q, done_d;
   logic [PtrW-1:0]   wptr_q, rptr_q;
   logic [CntW-1:0]   count_q, count_d;
   logic [W-1:0]      mem_q [DEPTH];
   logic [DEPTH-1:0]  last_q;

   logic push, pop, valid, push_last;

   // The PEs shift on every edge where the enable is high, so that is also the capture edge.
   assign push      = en_q;
   assign valid     = (count_q != '0);
   assign pop       = valid && stream.outReady;
   assign push_last = (shifts_q == ShW'(ROWS - 1));

   always_comb begin
      state_d  = state_q;
      shifts_d = shifts_q;
      done_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StDrain;
               shifts_d = '0;
            end
         end
         StDrain: begin
            if (en_q) begin
               shifts_d = shifts_q + 1'b1;
            end
            if (shifts_d == ShW'(ROWS)) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            // Stay in FLUSH through the done cycle so a start coinciding with done is ignored.
            if (done_q) begin
               state_d = StIdle;
            end else if (count_q == '0) begin
               done_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Reserve a slot for the in-flight shift; pops are ignored, so a freed slot re-enables
      // shifting one cycle after the pop lands in count.
      en_d = (state_d == StDrain) && !mulBusy && (32'(shifts_d) < ROWS) &&
             ((32'(count_q) + 32'(en_q)) < DEPTH);

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StIdle;
         shifts_q <= '0;
         en_q     <= 1'b0;
         done_q   <= 1'b0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         shifts_q <= shifts_d;
         en_q     <= en_d;
         done_q   <= done_d;
         count_q  <= count_d;
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
      end
   end

   // Storage carries no reset; valid gates everything read from it.
   always_ff @(posedge clock) begin
      if (push && !reset) begin
         mem_q[wptr_q]  <= chainTail;
         last_q[wptr_q] <= push_last;
      end
   end

   assign stream.outValid = valid;
   assign stream.outData  = valid ? mem_q[rptr_q] : '0;
   assign stream.outLast  = valid && last_q[rptr_q];
   assign enableShiftOut  = en_q;
   assign chainHead       = '0;
   assign busy            = (state_q != StIdle);
   assign done            = done_q;

endmodule
